// File: rtl/gate_eval_pkg.sv
// Shared definitions for the mux-built bitwise gate pipeline.
package gate_eval_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    localparam int CNT_W  = 16;
    localparam int STAGES = 2;

endpackage

// File: rtl/gate_eval_pipe_mux.sv
// 1-bit 2:1 mux, the only primitive the gate datapath is built from.
module gate_eval_pipe_mux (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/gate_eval_pipe.sv
// Two-stage valid/ready pipeline evaluating AND/OR/XOR/NAND with mux-only gates.
module gate_eval_pipe
    import gate_eval_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [W-1:0]     up_a,
    input  logic [W-1:0]     up_b,
    input  logic [1:0]       up_op,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [W-1:0]     down_res,
    output logic [CNT_W-1:0] done_cnt
);

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
    } req_t;

    req_t              req, s1;
    logic [STAGES:1]   vld_pipe;
    logic              s1_adv, s2_adv;

    logic [W-1:0] nb, g_and, g_or, g_xor, g_nand, p_lo, p_hi, res;

    assign req = '{a: up_a, b: up_b, op: up_op};

    assign s2_adv     = ~vld_pipe[2] | down_ready;
    assign s1_adv     = ~vld_pipe[1] | s2_adv;
    assign up_ready   = ~vld_pipe[1] | s1_adv;
    assign down_valid = vld_pipe[2];

    // Per bit: five gate muxes, then op[0] picks within each pair and op[1] between pairs.
    for (genvar i = 0; i < W; i++) begin : g_bit
        gate_eval_pipe_mux u_not  (.d0(1'b1),     .d1(1'b0),      .sel(s1.b[i]),  .y(nb[i]));
        gate_eval_pipe_mux u_and  (.d0(1'b0),     .d1(s1.b[i]),   .sel(s1.a[i]),  .y(g_and[i]));
        gate_eval_pipe_mux u_or   (.d0(s1.b[i]),  .d1(1'b1),      .sel(s1.a[i]),  .y(g_or[i]));
        gate_eval_pipe_mux u_xor  (.d0(s1.b[i]),  .d1(nb[i]),     .sel(s1.a[i]),  .y(g_xor[i]));
        gate_eval_pipe_mux u_nand (.d0(1'b1),     .d1(nb[i]),     .sel(s1.a[i]),  .y(g_nand[i]));
        gate_eval_pipe_mux u_plo  (.d0(g_and[i]), .d1(g_or[i]),   .sel(s1.op[0]), .y(p_lo[i]));
        gate_eval_pipe_mux u_phi  (.d0(g_xor[i]), .d1(g_nand[i]), .sel(s1.op[0]), .y(p_hi[i]));
        gate_eval_pipe_mux u_sel  (.d0(p_lo[i]),  .d1(p_hi[i]),   .sel(s1.op[1]), .y(res[i]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            s1       <= '0;
            down_res <= '0;
            done_cnt <= '0;
        end else begin
            if (s1_adv) vld_pipe[1] <= up_valid;
            // Operands load only on an accept, so an idle pipeline holds all state.
            if (up_valid && s1_adv) s1 <= req;
            if (s2_adv) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) down_res <= res;
            end
            if (vld_pipe[2] && down_ready) done_cnt <= done_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_gate_eval_pipe.sv
// Bench for gate_eval_pipe: directed scenarios plus randomized handshake traffic.
module tb_gate_eval_pipe;
    import gate_eval_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        up_valid = 1'b0, up_ready;
    logic [7:0]  up_a = '0, up_b = '0;
    logic [1:0]  up_op = '0;
    logic        down_valid, down_ready = 1'b0;
    logic [7:0]  down_res;
    logic [15:0] done_cnt;

    logic        e_valid = 1'b0, e_ready, e_dv, e_dr = 1'b1;
    logic [0:0]  e_a = '0, e_b = '0, e_res;
    logic [1:0]  e_op = '0;
    logic [15:0] e_cnt;

    int tests = 0, fails = 0, exp_cnt = 0;

    gate_eval_pipe #(.W(8)) dut (
        .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(up_ready),
        .up_a(up_a), .up_b(up_b), .up_op(up_op), .down_valid(down_valid),
        .down_ready(down_ready), .down_res(down_res), .done_cnt(done_cnt)
    );

    gate_eval_pipe #(.W(1)) dut1 (
        .clk(clk), .rst(rst), .up_valid(e_valid), .up_ready(e_ready),
        .up_a(e_a), .up_b(e_b), .up_op(e_op), .down_valid(e_dv),
        .down_ready(e_dr), .down_res(e_res), .done_cnt(e_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        case (op_e'(op))
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    // Samples the handshakes that will fire on the coming edge, then advances one cycle.
    task automatic clk_step(output bit uf, output bit df, output logic [7:0] r);
        uf = up_valid && up_ready;
        df = down_valid && down_ready;
        r  = down_res;
        @(posedge clk);
        #1;
        if (df) exp_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; up_valid = 1'b0; down_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (up_ready !== 1'b1) begin fails++; $display("FAIL reset_up_ready got %b exp 1", up_ready); end
        tests++; if (down_valid !== 1'b0) begin fails++; $display("FAIL reset_down_valid got %b exp 0", down_valid); end
        tests++; if (down_res !== 8'h00) begin fails++; $display("FAIL reset_down_res got %h exp 00", down_res); end
        tests++; if (done_cnt !== 16'h0) begin fails++; $display("FAIL reset_done_cnt got %0d exp 0", done_cnt); end
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_vector();
        logic [7:0] expv [4];
        bit uf, df; logic [7:0] r; bit edv;
        expv = '{8'hC0, 8'hFC, 8'h3C, 8'h3F};
        down_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin up_valid = 1'b1; up_a = 8'hF0; up_b = 8'hCC; up_op = 2'(i); end
            else up_valid = 1'b0;
            #1;
            edv = (i >= 2 && i < 6);
            tests++; if (down_valid !== edv) begin fails++; $display("FAIL vec_valid cyc %0d got %b exp %b", i, down_valid, edv); end
            if (edv) begin
                tests++; if (down_res !== expv[i-2]) begin fails++; $display("FAIL vec_res cyc %0d got %h exp %h", i, down_res, expv[i-2]); end
            end
            clk_step(uf, df, r);
        end
        tests++; if (done_cnt !== 16'd4) begin fails++; $display("FAIL vec_done_cnt got %0d exp 4", done_cnt); end
    endtask

    task automatic test_backpressure();
        logic [7:0] pa [3], pb [3]; logic [1:0] po [3];
        int idx = 0, got = 0;
        bit uf, df; logic [7:0] r, e;
        for (int i = 0; i < 3; i++) begin pa[i] = 8'($urandom); pb[i] = 8'($urandom); po[i] = 2'($urandom); end
        down_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (idx < 3) begin up_valid = 1'b1; up_a = pa[idx]; up_b = pb[idx]; up_op = po[idx]; end
            else up_valid = 1'b0;
            #1;
            clk_step(uf, df, r);
            if (uf) idx++;
        end
        #1;
        tests++; if (idx !== 2) begin fails++; $display("FAIL bp_accepted got %0d exp 2", idx); end
        tests++; if (up_ready !== 1'b0) begin fails++; $display("FAIL bp_up_ready got %b exp 0", up_ready); end
        e = ref_op(pa[0], pb[0], po[0]);
        tests++; if (down_valid !== 1'b1 || down_res !== e) begin
            fails++; $display("FAIL bp_hold got v=%b %h exp v=1 %h", down_valid, down_res, e);
        end
        down_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (idx < 3) begin up_valid = 1'b1; up_a = pa[idx]; up_b = pb[idx]; up_op = po[idx]; end
            else up_valid = 1'b0;
            #1;
            clk_step(uf, df, r);
            if (uf) idx++;
            if (df) begin
                tests++;
                if (got >= 3) begin fails++; $display("FAIL bp_extra got %h exp none", r); end
                else begin
                    e = ref_op(pa[got], pb[got], po[got]);
                    if (r !== e) begin fails++; $display("FAIL bp_order idx %0d got %h exp %h", got, r, e); end
                end
                got++;
            end
        end
        up_valid = 1'b0;
        tests++; if (got !== 3 || idx !== 3) begin fails++; $display("FAIL bp_count got out=%0d in=%0d exp 3/3", got, idx); end
    endtask

    task automatic test_random();
        logic [7:0] q [$];
        int sent = 0, recv = 0, cyc = 0;
        bit pend = 0, stall = 0, uf, df;
        logic [7:0] r, hold = '0, e;
        up_valid = 1'b0;
        while (recv < 1000 && cyc < 20000) begin
            if (!pend && sent < 1000 && $urandom_range(0, 3) != 0) begin
                up_a = 8'($urandom); up_b = 8'($urandom); up_op = 2'($urandom);
                up_valid = 1'b1; pend = 1'b1;
            end
            down_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (stall) begin
                tests++;
                if (down_valid !== 1'b1 || down_res !== hold) begin
                    fails++; $display("FAIL rand_stall got v=%b %h exp v=1 %h", down_valid, down_res, hold);
                end
            end
            stall = down_valid && !down_ready;
            hold  = down_res;
            if (up_valid && up_ready) q.push_back(ref_op(up_a, up_b, up_op));
            clk_step(uf, df, r);
            if (uf) begin sent++; pend = 1'b0; up_valid = 1'b0; end
            if (df) begin
                tests++;
                if (q.size() == 0) begin fails++; $display("FAIL rand_extra got %h exp none", r); end
                else begin
                    e = q.pop_front();
                    if (r !== e) begin fails++; $display("FAIL rand_res n=%0d got %h exp %h", recv, r, e); end
                end
                recv++;
            end
            cyc++;
        end
        up_valid = 1'b0;
        down_ready = 1'b1;
        tests++; if (recv !== 1000) begin fails++; $display("FAIL rand_timeout got %0d exp 1000", recv); end
        tests++; if (done_cnt !== 16'(exp_cnt)) begin fails++; $display("FAIL rand_done_cnt got %0d exp %0d", done_cnt, 16'(exp_cnt)); end
    endtask

    task automatic test_reset_midflight();
        bit uf, df, stale = 0; logic [7:0] r, e;
        down_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            up_valid = 1'b1; up_a = 8'($urandom); up_b = 8'($urandom); up_op = 2'($urandom);
            #1;
            clk_step(uf, df, r);
        end
        up_valid = 1'b0;
        #1;
        tests++; if (down_valid !== 1'b1 || up_ready !== 1'b0) begin
            fails++; $display("FAIL rst_fill got v=%b rdy=%b exp v=1 rdy=0", down_valid, up_ready);
        end
        #2 rst = 1'b1;
        #1;
        tests++; if (down_valid !== 1'b0) begin fails++; $display("FAIL rst_async_valid got %b exp 0", down_valid); end
        tests++; if (done_cnt !== 16'h0) begin fails++; $display("FAIL rst_async_cnt got %0d exp 0", done_cnt); end
        tests++; if (up_ready !== 1'b1) begin fails++; $display("FAIL rst_async_ready got %b exp 1", up_ready); end
        @(posedge clk);
        #2 rst = 1'b0;
        exp_cnt = 0;
        down_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (down_valid) stale = 1'b1;
            clk_step(uf, df, r);
        end
        tests++; if (stale) begin fails++; $display("FAIL rst_stale got valid=1 exp 0"); end
        up_valid = 1'b1; up_a = 8'($urandom); up_b = 8'($urandom); up_op = 2'($urandom);
        e = ref_op(up_a, up_b, up_op);
        #1;
        clk_step(uf, df, r);
        up_valid = 1'b0;
        tests++; if (!uf) begin fails++; $display("FAIL rst_accept got 0 exp 1"); end
        #1;
        tests++; if (down_valid !== 1'b0) begin fails++; $display("FAIL rst_lat1 got %b exp 0", down_valid); end
        clk_step(uf, df, r);
        tests++; if (down_valid !== 1'b1 || down_res !== e) begin
            fails++; $display("FAIL rst_lat2 got v=%b %h exp v=1 %h", down_valid, down_res, e);
        end
        #1;
        clk_step(uf, df, r);
    endtask

    task automatic test_exhaustive();
        logic [3:0] tt [4];
        logic [1:0] ab;
        bit seen;
        tt = '{4'b1000, 4'b1110, 4'b0110, 4'b0111};
        for (int op = 0; op < 4; op++) begin
            for (int a = 0; a < 2; a++) begin
                for (int b = 0; b < 2; b++) begin
                    e_valid = 1'b1; e_a = a[0:0]; e_b = b[0:0]; e_op = 2'(op);
                    ab = {a[0], b[0]};
                    @(posedge clk); #1;
                    e_valid = 1'b0;
                    seen = 1'b0;
                    for (int k = 0; k < 5 && !seen; k++) begin
                        if (e_dv) seen = 1'b1;
                        else begin @(posedge clk); #1; end
                    end
                    tests++;
                    if (!seen || e_res[0] !== tt[op][ab]) begin
                        fails++; $display("FAIL tt op=%0d a=%0d b=%0d got v=%b %b exp 1 %b", op, a, b, e_dv, e_res, tt[op][ab]);
                    end
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        int acc = 0;
        bit chk = 0, uf, df;
        logic [7:0] r;
        rst = 1'b1;
        #2 rst = 1'b0;
        exp_cnt = 0;
        down_ready = 1'b1;
        for (int cyc = 0; cyc < 70000 && exp_cnt < 65536; cyc++) begin
            up_valid = (acc < 65536);
            up_a = 8'(cyc); up_b = 8'hA5; up_op = 2'(cyc);
            #1;
            clk_step(uf, df, r);
            if (uf) acc++;
            if (exp_cnt == 65535 && !chk) begin
                chk = 1'b1;
                tests++; if (done_cnt !== 16'hFFFF) begin fails++; $display("FAIL wrap_max got %0d exp 65535", done_cnt); end
            end
        end
        up_valid = 1'b0;
        tests++; if (exp_cnt !== 65536) begin fails++; $display("FAIL wrap_timeout got %0d exp 65536", exp_cnt); end
        tests++; if (done_cnt !== 16'h0000) begin fails++; $display("FAIL wrap_zero got %0d exp 0", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_vector();
        test_backpressure();
        test_random();
        test_reset_midflight();
        test_exhaustive();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gate_eval_pipe.md
GATE_EVAL_PIPE -- requirements
Module: gate_eval_pipe

Interface
REQ-001 Parameter: W, default 8, operand/result width in bits (W >= 1).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 up_valid  input  1  the upstream operand pair is valid.
REQ-005 up_ready  output  1  the block accepts the operand pair this cycle.
REQ-006 up_a  input  W  operand A.
REQ-007 up_b  input  W  operand B.
REQ-008 up_op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-009 down_valid  output  1  down_res holds a valid result.
REQ-010 down_ready  input  1  the downstream block takes the result this cycle.
REQ-011 down_res  output  W  bitwise result of up_op applied to A and B.
REQ-012 done_cnt  output  16  count of results taken downstream; wraps from 0xFFFF to 0.

Function
REQ-013 Transfer on either side SHALL occur only when valid and ready are both 1 in the same cycle.
REQ-014 The pipeline SHALL have two register stages: S1 (operands and op) and S2 (result); accept-to-down_valid latency is exactly 2 cycles when there is no backpressure.
REQ-015 Each stage SHALL hold a valid bit; stage k advances when it is empty or when the next stage advances; S2 advances when ~s2_valid | down_ready.
REQ-016 up_ready SHALL equal ~s1_valid | s1_advance, combinational and independent of up_valid.
REQ-017 With down_ready held at 1, throughput SHALL be one result per cycle.
REQ-018 While down_valid=1 and down_ready=0, down_res SHALL stay stable and S1 contents SHALL be held.
REQ-019 Both stages full with down_ready=0 SHALL drive up_ready=0; no operand pair is dropped or duplicated.
REQ-020 Per-bit gates SHALL be built only from 2:1 mux instances and constants 0/1:
- AND = mux(d0=0, d1=b, sel=a)
- OR = mux(d0=b, d1=1, sel=a)
- NOT b = mux(d0=1, d1=0, sel=b)
- XOR = mux(d0=b, d1=~b, sel=a)
- NAND = mux(d0=1, d1=~b, sel=a)
REQ-021 The op is selected by a two-level mux tree: op[0] selects within {AND,OR} and {XOR,NAND}; op[1] selects between the two pairs.
REQ-022 The result SHALL be computed from S1 contents and registered into S2.
REQ-023 done_cnt SHALL increment by 1 on each down-side transfer, and only then.
REQ-024 up_valid=0 with an empty pipeline SHALL leave all state unchanged.

Reset
REQ-025 rst=1 SHALL immediately clear both valid bits, down_res to 0, and done_cnt to 0; up_ready reads 1 while rst=1.
REQ-026 Reset during operation SHALL discard in-flight data without emitting it; the first accept after rst falls produces down_valid 2 cycles later.

Structure
REQ-027 The shared package gate_eval_pkg SHALL hold the op enum (OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NAND=2'b11) and the counter width constant (16).
REQ-028 The sub-module SHALL be the existing 1-bit mux (d0, d1, sel, y), instantiated per bit in a generate loop; no behavioural operators are used on the datapath.

Verification
REQ-029 W=8, down_ready=1, A=8'hF0, B=8'hCC with ops 00/01/10/11 on consecutive cycles -> down_res = 8'hC0, 8'hFC, 8'h3C, 8'h3F on cycles +2..+5; done_cnt=4.
REQ-030 down_ready=0, 3 pairs offered back-to-back -> two are accepted, then up_ready=0; down_res holds the first result; release -> all 3 results emerge in order, with none lost or duplicated.
REQ-031 Randomized valid/ready toggling over 1000 transactions against a bitwise reference model -> exact match, in order.
REQ-032 rst asserted while both stages are full -> down_valid=0 and done_cnt=0 in the same cycle, and no stale result appears afterwards.
REQ-033 done_cnt forced near wrap (65535 transfers) -> the next transfer gives done_cnt=0.
REQ-034 Exhaustive 1-bit check: all a, b and op combinations -> results match the truth tables for AND, OR, XOR and NAND.
